// File: rtl/dt_res_packer_if.sv
// Result-path bus between the distance-map packer, the res RAM read port
// and the packed-word write port, plus frame control and statistics.
interface dt_res_packer_if;
  logic        start;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        pk_wr;
  logic [9:0]  pk_addr;
  logic [15:0] pk_do;
  logic [7:0]  max_dist;
  logic [14:0] set_cnt;
  logic        busy;
  logic        done;

  modport master (
    input  start, res_di,
    output res_rd, res_addr, pk_wr, pk_addr, pk_do, max_dist, set_cnt, busy, done
  );

  modport slave (
    output start, res_di,
    input  res_rd, res_addr, pk_wr, pk_addr, pk_do, max_dist, set_cnt, busy, done
  );
endinterface

// File: rtl/dt_res_packer.sv
// Reads the 128x128 distance map back from the res RAM, thresholds it into a
// 1-bit image packed 16 pixels per word (first pixel in bit 15) and keeps stats.
module dt_res_packer #(
  parameter logic [7:0] THRESH = 8'd1,
  parameter int         PIX_N  = 16384
) (
  input logic            clk,
  input logic            reset,
  dt_res_packer_if.master bus
);

  localparam int DATA_W = 8;
  localparam int AW     = $clog2(PIX_N);
  localparam int WAW    = AW - 4;
  localparam logic [AW-1:0]  LAST_PIX  = AW'(PIX_N - 1);
  localparam logic [WAW-1:0] LAST_WORD = WAW'(PIX_N / 16 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic thresh_bit(input logic [DATA_W-1:0] d);
    return (d >= THRESH);
  endfunction

  function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            vld_p1_q, vld_p1_d;
  logic [AW-1:0]   idx_p1_q, idx_p1_d;
  logic [14:0]     shift_q, shift_d;
  logic [7:0]      max_q, max_d;
  logic [14:0]     cnt_q, cnt_d;
  logic            pk_wr_q, pk_wr_d;
  logic [WAW-1:0]  pk_addr_q, pk_addr_d;
  logic [15:0]     pk_do_q, pk_do_d;

  logic            rd;
  logic            start_acc;
  logic            cap_bit;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; DONE accepts start exactly like IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bus.start) state_d = S_RUN;
      S_RUN:          if (addr_q == LAST_PIX) state_d = S_DRAIN;
      S_DRAIN:        if (pk_wr_q && (pk_addr_q == LAST_WORD)) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rd       = (state_q == S_RUN);
    bus.busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    bus.done = (state_q == S_DONE);
  end

  assign start_acc = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign cap_bit   = thresh_bit(bus.res_di);

  // Stage p0: read address generation
  always_comb begin
    addr_d   = addr_q;
    if (start_acc)                        addr_d = '0;
    else if (rd && (addr_q != LAST_PIX))  addr_d = addr_q + AW'(1);
    vld_p1_d = rd;
    idx_p1_d = addr_q;
  end

  // Stage p1: res_di valid; threshold, shift, stats and word assembly
  always_comb begin
    shift_d   = shift_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    pk_wr_d   = 1'b0;
    pk_addr_d = pk_addr_q;
    pk_do_d   = pk_do_q;
    if (start_acc) begin
      shift_d = '0;
      max_d   = '0;
      cnt_d   = '0;
    end
    if (vld_p1_q) begin
      shift_d = {shift_q[13:0], cap_bit};
      max_d   = max_u(max_q, bus.res_di);
      cnt_d   = cnt_q + 15'(cap_bit);
      if (idx_p1_q[3:0] == 4'hF) begin
        pk_wr_d   = 1'b1;
        pk_addr_d = idx_p1_q[AW-1:4];
        pk_do_d   = {shift_q, cap_bit};
      end
    end
  end

  // Stage p2: registered write port and statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      vld_p1_q  <= 1'b0;
      idx_p1_q  <= '0;
      shift_q   <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
      pk_wr_q   <= 1'b0;
      pk_addr_q <= '0;
      pk_do_q   <= '0;
    end else begin
      addr_q    <= addr_d;
      vld_p1_q  <= vld_p1_d;
      idx_p1_q  <= idx_p1_d;
      shift_q   <= shift_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      pk_wr_q   <= pk_wr_d;
      pk_addr_q <= pk_addr_d;
      pk_do_q   <= pk_do_d;
    end
  end

  assign bus.res_rd   = rd;
  assign bus.res_addr = addr_q;
  assign bus.pk_wr    = pk_wr_q;
  assign bus.pk_addr  = pk_addr_q;
  assign bus.pk_do    = pk_do_q;
  assign bus.max_dist = max_q;
  assign bus.set_cnt  = cnt_q;

endmodule

// File: doc/dt_res_packer.md
Name: dt_res_packer

Overview:
- Reads back the 128x128 8-bit distance map that the distance-transform engine left in the res RAM.
- Thresholds each pixel against a programmable level and repacks the result into 16-pixel binary words, in the same format as the sti ROM (1024 x 16, first pixel in bit 15).
- Writes the packed words to a pk memory port and reports statistics: maximum distance and set-pixel count.
- Sits after DT in the result path. Owns the res RAM read side while DT is idle.

Parameters:
- THRESH, 8'd1, pixel bit = 1 when res_di >= THRESH.
- PIX_N, 16384, pixels per frame (fixed 128x128; the words count is PIX_N/16).

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
- res_rd  output  1  res RAM read strobe.
- res_addr  output  14  res RAM read address, raster order.
- res_di  input  8  res RAM read data, valid the cycle after res_rd/res_addr.
- pk_wr  output  1  one-cycle write strobe for a packed word.
- pk_addr  output  10  packed word address (pixel index / 16).
- pk_do  output  16  packed word, bit 15 = lowest-address pixel.
- max_dist  output  8  running maximum of res_di over the frame.
- set_cnt  output  15  number of pixels with bit = 1 (0..16384).
- busy  output  1  high from the first read cycle until done rises.
- done  output  1  level; high after the final word is written, cleared by the next accepted start.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state = IDLE.
  - res_rd, pk_wr, busy, done = 0.
  - res_addr, pk_addr, pk_do, max_dist, set_cnt = 0.
  - Shift register and pixel counters cleared.
  - No partial word is written.
- State IDLE:
  - When start = 1: go to RUN, clear done, max_dist and set_cnt.
  - The first RUN cycle drives res_rd = 1, res_addr = 0.
- State RUN:
  - res_rd = 1 every cycle; res_addr increments by 1 each cycle.
  - After the cycle with res_addr = 16383, go to DRAIN with res_rd = 0. res_addr holds 16383.
- Capture pipeline (active in RUN and DRAIN):
  - The cycle after a read, res_di is valid. The bit (res_di >= THRESH) shifts into a 15-bit shift register, MSB first.
  - max_dist updates to the larger of max_dist and res_di; the comparison is unsigned.
  - set_cnt increments when the bit is 1.
- Word write:
  - When the captured pixel index mod 16 = 15, the next cycle drives pk_wr = 1, pk_addr = index/16, pk_do = {shift[14:0], bit}.
  - pk_wr is a single-cycle pulse; pk_addr and pk_do hold until the next write.
- State DRAIN:
  - Waits for the last capture and the word-1023 write.
  - Then goes to DONE: done = 1, busy = 0.
- State DONE:
  - Behaves as IDLE; done stays high until a start is accepted.
- Timing, with cycle 0 = first cycle of res_rd = 1:
  - res_rd is high for exactly 16384 cycles (0..16383).
  - Word 0 pk_wr is in cycle 17.
  - Word k pk_wr is in cycle 17 + 16k; the last (k = 1023) is in cycle 16385.
  - done rises in cycle 16386. busy is high for cycles 0..16385.
- Boundaries:
  - start while busy is ignored.
  - start held high in DONE begins a new frame every time the state returns to DONE.
  - THRESH = 0 makes every bit 1.
  - set_cnt is 15 bits so that 16384 does not wrap.
  - res_addr never exceeds 16383; pk_addr never exceeds 1023.

Test Plan:
- All-zero res RAM, THRESH=1, pulse start:
  - 1024 pk_wr pulses, all pk_do = 16'h0000.
  - max_dist = 0, set_cnt = 0.
  - done rises 16386 cycles after the first res_rd.
- Pixel 0 = 5, pixel 17 = 1, rest 0:
  - word 0 = 16'h8000, word 1 = 16'h4000, others 0.
  - max_dist = 5, set_cnt = 2.
- Full frame of value 8'd200, THRESH=201:
  - all words 16'h0000, max_dist = 200, set_cnt = 0.
- Same frame, THRESH=200:
  - all words 16'hFFFF, set_cnt = 16384 (no wrap).
- Reset asserted at cycle 5000 of a frame:
  - all outputs 0 immediately.
  - No further pk_wr; the next start restarts at res_addr 0.
- Second start pulse at cycle 100 of a frame:
  - ignored, with identical pk_wr sequence and timing.
- A start after done:
  - done clears, max_dist and set_cnt reset.
  - The new frame's timing matches the first frame.
